change_dispenser: RTL

- Pays out the vending machine's return_change amount as physical coins through a coin hopper.
- Consumes the amount on a valid/ready handshake and breaks it greedily into 10/5/2/1 denominations.
- Issues one hopper eject request per coin, waits for the hopper acknowledge, and reports completion or a hopper fault.
- Sits between the vending-machine controller's change output and the coin-hopper driver.

---
 rtl/vending_pkg.sv | 32 +++
 rtl/change_dispenser_coin_selector.sv | 25 ++
 rtl/change_dispenser.sv | 129 ++++++++++++
 3 files changed

// File: rtl/vending_pkg.sv
// Shared types and constants for the vending-machine change path.
// Holds the dispenser state encoding, coin denominations and coin_sel codes.
package vending_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_EJECT  = 3'd2,
        ST_DONE   = 3'd3,
        ST_FAULT  = 3'd4
    } disp_state_e;

    localparam int DENOM_10 = 10;
    localparam int DENOM_5  = 5;
    localparam int DENOM_2  = 2;
    localparam int DENOM_1  = 1;

    localparam logic [1:0] SEL_10 = 2'd0;
    localparam logic [1:0] SEL_5  = 2'd1;
    localparam logic [1:0] SEL_2  = 2'd2;
    localparam logic [1:0] SEL_1  = 2'd3;

    function automatic int denom_value(input logic [1:0] sel);
        case (sel)
            SEL_10:  return DENOM_10;
            SEL_5:   return DENOM_5;
            SEL_2:   return DENOM_2;
            default: return DENOM_1;
        endcase
    endfunction

endpackage

// File: rtl/change_dispenser_coin_selector.sv
// Greedy coin choice: largest denomination not exceeding the amount.
// Purely combinational so other blocks can reuse it for availability checks.
module coin_selector
    import vending_pkg::*;
#(
    parameter int AMOUNT_W = 7
) (
    input  logic [AMOUNT_W-1:0] amount,
    output logic [1:0]          sel,
    output logic [AMOUNT_W-1:0] denom
);

    always_comb begin
        sel = SEL_1;
        if (amount >= AMOUNT_W'(DENOM_10)) begin
            sel = SEL_10;
        end else if (amount >= AMOUNT_W'(DENOM_5)) begin
            sel = SEL_5;
        end else if (amount >= AMOUNT_W'(DENOM_2)) begin
            sel = SEL_2;
        end
        denom = AMOUNT_W'(denom_value(sel));
    end

endmodule

// File: rtl/change_dispenser.sv
// Pays a change amount out through the coin hopper one coin at a time,
// waiting for each hopper acknowledge and flagging a fault on ack timeout.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int AMOUNT_W    = 7,
    parameter int CNT_W       = 5,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                change_valid,
    input  logic [AMOUNT_W-1:0] change_amount,
    output logic                change_ready,
    output logic                coin_eject,
    output logic [1:0]          coin_sel,
    input  logic                coin_ack,
    output logic                busy,
    output logic                done,
    output logic                fault,
    output logic [AMOUNT_W-1:0] remaining,
    output logic [CNT_W-1:0]    coins_paid
);

    localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    disp_state_e         state_q, state_d;
    logic [1:0]          coin_sel_q, coin_sel_d;
    logic [AMOUNT_W-1:0] denom_q, denom_d;
    logic [AMOUNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0]    coins_paid_q, coins_paid_d;
    logic                fault_q, fault_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;

    logic [1:0]          pick_sel;
    logic [AMOUNT_W-1:0] pick_denom;

    coin_selector #(
        .AMOUNT_W (AMOUNT_W)
    ) u_coin_selector (
        .amount (remaining_q),
        .sel    (pick_sel),
        .denom  (pick_denom)
    );

    always_comb begin
        state_d      = state_q;
        coin_sel_d   = coin_sel_q;
        denom_d      = denom_q;
        remaining_d  = remaining_q;
        coins_paid_d = coins_paid_q;
        fault_d      = fault_q;
        tmo_d        = tmo_q;

        case (state_q)
            ST_IDLE: begin
                if (change_valid) begin
                    remaining_d  = change_amount;
                    coins_paid_d = '0;
                    fault_d      = 1'b0;
                    state_d      = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (remaining_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    coin_sel_d = pick_sel;
                    denom_d    = pick_denom;
                    tmo_d      = '0;
                    state_d    = ST_EJECT;
                end
            end
            ST_EJECT: begin
                // An ack arriving on the final timeout cycle still wins.
                if (coin_ack) begin
                    remaining_d  = remaining_q - denom_q;
                    coins_paid_d = coins_paid_q + CNT_W'(1);
                    state_d      = ST_SELECT;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_FAULT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_FAULT: begin
                fault_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            coin_sel_q   <= '0;
            denom_q      <= '0;
            remaining_q  <= '0;
            coins_paid_q <= '0;
            fault_q      <= 1'b0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            coin_sel_q   <= coin_sel_d;
            denom_q      <= denom_d;
            remaining_q  <= remaining_d;
            coins_paid_q <= coins_paid_d;
            fault_q      <= fault_d;
            tmo_q        <= tmo_d;
        end
    end

    assign change_ready = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign coin_eject   = (state_q == ST_EJECT);
    assign done         = (state_q == ST_DONE);
    assign coin_sel     = coin_sel_q;
    assign fault        = fault_q;
    assign remaining    = remaining_q;
    assign coins_paid   = coins_paid_q;

endmodule
